// File: rtl/vec_sweep_sequencer_if.sv
// Control and status bundle for the vector sweep sequencer.
// The slave side is the sequencer; the master side is the harness.
interface vec_sweep_sequencer_if #(
  parameter int DIGITS = 8,
  parameter int CNTW   = 16
) ();
  localparam int VW = 2 * DIGITS;

  logic            start;
  logic            abort;
  logic            mismatch;
  logic [VW-1:0]   vec;
  logic            apply;
  logic            sample;
  logic            busy;
  logic            done;
  logic            aborted;
  logic [CNTW-1:0] fail_count;
  logic [VW-1:0]   first_fail;
  logic            first_fail_valid;

  modport slave (
    input  start, abort, mismatch,
    output vec, apply, sample, busy, done,
    output aborted, fail_count,
    output first_fail, first_fail_valid
  );

  modport master (
    output start, abort, mismatch,
    input  vec, apply, sample, busy, done,
    input  aborted, fail_count,
    input  first_fail, first_fail_valid
  );
endinterface

// File: rtl/vec_sweep_sequencer.sv
// Steps a four-valued input vector through every combination,
// settles, samples an external mismatch flag and keeps statistics.
module vec_sweep_sequencer #(
  parameter int DIGITS = 8,
  parameter int SETTLE = 4,
  parameter int CNTW   = 16
) (
  input  logic clk,
  input  logic reset,
  vec_sweep_sequencer_if.slave bus
);
  localparam int VW = 2 * DIGITS;
  localparam int SW = (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SLOAD =
    (SETTLE == 0) ? '0 : SW'(SETTLE - 1);
  localparam logic [CNTW-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0] fc_q, fc_d;
  logic [VW-1:0]   ff_q, ff_d;
  logic            ffv_q, ffv_d;
  logic            ab_q, ab_d;
  logic            apply_q, sample_q;
  logic            busy_q, done_q;
  logic            in_busy;

  assign in_busy = (state_q == S_APPLY) ||
                   (state_q == S_SETTLE) ||
                   (state_q == S_CHECK);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    ab_d    = ab_q;
    // abort beats CHECK, so a mismatch in that cycle is dropped
    if (in_busy && bus.abort) begin
      state_d = S_DONE;
      ab_d    = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d = S_APPLY;
            vec_d   = '0;
            fc_d    = '0;
            ff_d    = '0;
            ffv_d   = 1'b0;
            ab_d    = 1'b0;
          end
        end
        S_APPLY: begin
          cnt_d   = SLOAD;
          state_d = (SETTLE > 0) ? S_SETTLE : S_CHECK;
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_CHECK: begin
          if (bus.mismatch) begin
            if (fc_q != CMAX) begin
              fc_d = fc_q + 1'b1;
            end
            if (!ffv_q) begin
              ff_d  = vec_q;
              ffv_d = 1'b1;
            end
          end
          if (&vec_q) begin
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + 1'b1;
            state_d = S_APPLY;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      fc_q     <= '0;
      ff_q     <= '0;
      ffv_q    <= 1'b0;
      ab_q     <= 1'b0;
      apply_q  <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      fc_q     <= fc_d;
      ff_q     <= ff_d;
      ffv_q    <= ffv_d;
      ab_q     <= ab_d;
      apply_q  <= (state_d == S_APPLY);
      sample_q <= (state_d == S_CHECK);
      busy_q   <= (state_d == S_APPLY) ||
                  (state_d == S_SETTLE) ||
                  (state_d == S_CHECK);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign bus.vec              = vec_q;
  assign bus.apply            = apply_q;
  assign bus.sample           = sample_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.aborted          = ab_q;
  assign bus.fail_count       = fc_q;
  assign bus.first_fail       = ff_q;
  assign bus.first_fail_valid = ffv_q;
endmodule

// File: tb/tb_vec_sweep_sequencer.sv
// Randomized sweeps of two sequencer configurations against
// a per-vector timing and statistics model.
module tb_vec_sweep_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic mism = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  vec_sweep_sequencer_if #(.DIGITS(2), .CNTW(16)) ia ();
  vec_sweep_sequencer_if #(.DIGITS(2), .CNTW(3))  ib ();

  vec_sweep_sequencer #(.DIGITS(2), .SETTLE(1), .CNTW(16)) u_a (
    .clk(clk), .reset(reset), .bus(ia)
  );
  vec_sweep_sequencer #(.DIGITS(2), .SETTLE(0), .CNTW(3)) u_b (
    .clk(clk), .reset(reset), .bus(ib)
  );

  assign ia.start    = start & ~sel;
  assign ib.start    = start & sel;
  assign ia.abort    = abort & ~sel;
  assign ib.abort    = abort & sel;
  assign ia.mismatch = mism;
  assign ib.mismatch = mism;

  wire [3:0]  o_vec  = sel ? ib.vec : ia.vec;
  wire        o_app  = sel ? ib.apply : ia.apply;
  wire        o_smp  = sel ? ib.sample : ia.sample;
  wire        o_busy = sel ? ib.busy : ia.busy;
  wire        o_done = sel ? ib.done : ia.done;
  wire        o_ab   = sel ? ib.aborted : ia.aborted;
  wire [15:0] o_fc   = sel ? {13'b0, ib.fail_count} : ia.fail_count;
  wire [3:0]  o_ff   = sel ? ib.first_fail : ia.first_fail;
  wire        o_ffv  = sel ? ib.first_fail_valid
                           : ia.first_fail_valid;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s sel=%0d got=%0h exp=%0h t=%0t",
               tag, sel, got, exp, $time);
    end
  endtask

  task automatic chk_rst();
    chk("rst_vec", 32'(o_vec), 0);
    chk("rst_apply", 32'(o_app), 0);
    chk("rst_sample", 32'(o_smp), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_abort", 32'(o_ab), 0);
    chk("rst_fc", 32'(o_fc), 0);
    chk("rst_ff", 32'(o_ff), 0);
    chk("rst_ffv", 32'(o_ffv), 0);
  endtask

  // ak<0: no abort; mid_t<0: no ignored start pulse
  task automatic sweep(input bit s, input logic [15:0] mask,
                       input int ak, input int aph,
                       input int mid_t);
    int p, ta, tend, nlast, efc, eff, cmax, k, ph;
    bit effv;
    sel  = s;
    p    = s ? 2 : 3;
    cmax = s ? 7 : 65535;
    ta   = (ak >= 0) ? 1 + ak * p + aph : -1;
    tend = (ak >= 0) ? ta + 1 : 1 + 16 * p;
    nlast = (ak >= 0) ? ak : 16;
    efc = 0;
    eff = 0;
    effv = 1'b0;
    for (int v = 0; v < nlast; v++) begin
      if (mask[v]) begin
        if (efc < cmax) efc++;
        if (!effv) begin
          effv = 1'b1;
          eff = v;
        end
      end
    end
    start = 1'b1;
    for (int t = 1; t <= tend; t++) begin
      @(negedge clk);
      k  = (t - 1) / p;
      ph = (t - 1) % p;
      if (t < tend) begin
        chk("busy", 32'(o_busy), 1);
        chk("done_low", 32'(o_done), 0);
        chk("apply", 32'(o_app), 32'(ph == 0));
        chk("sample", 32'(o_smp), 32'(ph == p - 1));
        if (ph == 0) chk("vec", 32'(o_vec), 32'(k));
      end
      start = (t == mid_t);
      abort = (t == ta);
      mism  = (ph == p - 1) ? mask[k] : 1'($urandom_range(0, 1));
      if (t == ta) mism = 1'b1;
    end
    chk("done", 32'(o_done), 1);
    chk("end_busy", 32'(o_busy), 0);
    chk("end_apply", 32'(o_app), 0);
    chk("end_sample", 32'(o_smp), 0);
    chk("end_vec", 32'(o_vec), (ak >= 0) ? 32'(ak) : 15);
    chk("aborted", 32'(o_ab), 32'(ak >= 0));
    chk("fail_count", 32'(o_fc), 32'(efc));
    chk("first_fail", 32'(o_ff), 32'(eff));
    chk("ff_valid", 32'(o_ffv), 32'(effv));
    // abort in DONE must be ignored and everything held
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("hold_done", 32'(o_done), 1);
    chk("hold_vec", 32'(o_vec), (ak >= 0) ? 32'(ak) : 15);
    chk("hold_fc", 32'(o_fc), 32'(efc));
    chk("hold_apply", 32'(o_app), 0);
  endtask

  task automatic reset_mid();
    sel = 1'b0;
    start = 1'b1;
    for (int t = 1; t <= 28; t++) begin
      @(negedge clk);
      start = 1'b0;
      mism = 1'($urandom_range(0, 1));
    end
    chk("pre_rst_vec", 32'(o_vec), 9);
    chk("pre_rst_apply", 32'(o_app), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_rst();
  endtask

  initial begin
    int ak, aph, mid, p;
    bit s;
    repeat (2) @(negedge clk);
    sel = 1'b0;
    chk_rst();
    sel = 1'b1;
    chk_rst();
    reset = 1'b0;
    @(negedge clk);
    sweep(1'b0, 16'h0000, -1, 0, -1);
    sweep(1'b0, 16'h0840, -1, 0, 10);
    sweep(1'b1, 16'hFFFF, -1, 0, -1);
    sweep(1'b0, 16'($urandom), 5, 2, -1);
    reset_mid();
    sweep(1'b0, 16'h0840, -1, 0, -1);
    for (int i = 0; i < 8; i++) begin
      s   = 1'($urandom_range(0, 1));
      p   = s ? 2 : 3;
      ak  = ($urandom_range(0, 2) == 0) ? -1
            : int'($urandom_range(0, 15));
      aph = int'($urandom_range(0, p - 1));
      mid = ($urandom_range(0, 1) == 0) ? -1
            : int'($urandom_range(1, 10));
      if (ak >= 0 && mid > 1 + ak * p + aph) mid = -1;
      sweep(s, 16'($urandom), ak, aph, mid);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/vec_sweep_sequencer.md
# vec_sweep_sequencer

Synthesizable sequencer for spec-versus-implementation equivalence sweeps. It steps an N-digit, four-valued input vector through every combination, holds each vector for a programmable settle time, then samples an external mismatch flag and accumulates failure statistics. It replaces hand-written nested `initial` loops in system tests, so one comparison harness can drive any pair of modules under test. A thin wrapper outside this block maps each 2-bit digit code onto the real signal value.

## Interface
- `DIGITS`, default 8: number of four-valued input positions. Range 1..15.
- `SETTLE`, default 4: idle cycles between applying a vector and sampling it. Range 0..255.
- `CNTW`, default 16: width of the failure counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a sweep. Accepted in IDLE or DONE.
- `abort`  in  1: end the sweep early. Honoured only while `busy`.
- `mismatch`  in  1: comparator result (impl `!==` spec). Valid only while `sample` is high.
- `vec`  out  2*DIGITS: current vector. Digit k is `vec[2k+1:2k]`. Codes: 0 = 0, 1 = 1, 2 = X, 3 = Z.
- `apply`  out  1: one-cycle pulse marking the cycle a new `vec` is first driven.
- `sample`  out  1: one-cycle pulse marking the cycle `mismatch` is captured.
- `busy`  out  1: high in APPLY, SETTLE and CHECK.
- `done`  out  1: high in DONE.
- `aborted`  out  1: the last sweep ended by `abort`.
- `fail_count`  out  CNTW: number of mismatching vectors. Saturates at 2^CNTW−1.
- `first_fail`  out  2*DIGITS: `vec` value of the first mismatching vector.
- `first_fail_valid`  out  1: `first_fail` holds a captured vector.

## Operation
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- `vec` is a plain binary counter. Digit 0 is the innermost, fastest-changing position. Digit DIGITS−1 is the outermost.
- IDLE or DONE with `start` high → APPLY, and in the same edge:
  - `vec` ← 0, `fail_count` ← 0, `first_fail` ← 0;
  - `first_fail_valid`, `aborted` ← 0.
- APPLY: `apply` = 1. Next state is SETTLE if `SETTLE` > 0, otherwise CHECK. Settle counter loads `SETTLE`−1.
- SETTLE: count down. At 0 → CHECK.
- CHECK: `sample` = 1. If `mismatch` is high:
  - `fail_count` increments, saturating;
  - if `first_fail_valid` = 0, then `first_fail` ← `vec` and `first_fail_valid` ← 1.
- CHECK exit: if `vec` is all ones → DONE, with `vec` held. Otherwise `vec` ← `vec`+1 → APPLY.
- DONE: `done` = 1. All outputs hold until the next `start` or `reset`.
- `abort` while `busy` → DONE next edge, with `aborted` ← 1 and `vec` held.
- `abort` has priority over CHECK. A `mismatch` sampled in the abort cycle is discarded and is not counted.
- `start` while `busy` is ignored. `abort` in IDLE or DONE is ignored.
- The settle counter is internal. It has width ceil(log2(`SETTLE`+1)), minimum 1.

## Timing
- Reset values:
  - state = IDLE;
  - `vec`, `fail_count`, `first_fail` = 0;
  - `apply`, `sample`, `busy`, `done`, `aborted`, `first_fail_valid` = 0.
- `reset` mid-sweep returns everything to the reset values on the next edge. No partial statistics are kept.
- All outputs are registered or decoded from state. There is no combinational path from any input to any output.
- `start` sampled at edge E0: `apply` = 1 and `vec` = 0 in the cycle after E0.
- Per-vector period is `SETTLE`+2 cycles: APPLY, then `SETTLE` × SETTLE, then CHECK.
- Vector k's APPLY cycle is 1 + k·(`SETTLE`+2) cycles after E0.
- `done` rises 1 + 4^DIGITS·(`SETTLE`+2) cycles after E0.
- `mismatch` is captured on the rising edge that ends the `sample` cycle.
- `fail_count` and `first_fail` update one cycle later. They are final once `done` = 1.

## Test plan
- Sweep with `mismatch` tied 0 (DIGITS=2, SETTLE=1): 16 `apply` pulses with `vec` = 0..15 in order, period 3 → `done` 49 cycles after the start edge, `fail_count` = 0, `first_fail_valid` = 0.
- Injected failures (DIGITS=2, SETTLE=1): `mismatch` high only when `vec` = 6 or 11 during `sample` → `fail_count` = 2, `first_fail` = 6, `first_fail_valid` = 1.
- Saturation (DIGITS=2, SETTLE=0, CNTW=3): `mismatch` tied 1 → period 2, `done` at 33 cycles, `fail_count` = 7, `first_fail` = 0.
- Abort (DIGITS=2, SETTLE=1): `abort` pulsed in vector 5's CHECK cycle while `mismatch` = 1 → DONE next edge, `aborted` = 1, `vec` = 5, mismatch not counted.
- Ignored and accepted start: `start` pulsed mid-sweep → no restart, vector order unchanged. `start` again in DONE → counters cleared, `vec` = 0, `apply` = 1 next cycle.
- Reset mid-sweep at vector 9 → all outputs equal the reset values one edge later. A subsequent `start` sweeps from `vec` = 0.
